// File: rtl/tns_pkg.sv
// Shared constants and per-group code functions for the two-group TSV
// (base-7 digit) encoder and decoder.
package tns_pkg;

    localparam int TNS_BLEN   = 6;
    localparam int TNS_NGROUP = 2;
    localparam int TNS_GRP_W  = 3;
    localparam int TNS_CODES  = 49;
    localparam int TNS_RADIX  = 7;

    // Digit 3 has two codes; the choice follows the group's previous MSB so
    // the MSB never toggles solely because of a 3.
    function automatic logic [TNS_GRP_W-1:0] tns_enc_grp(
        input logic [TNS_GRP_W-1:0] d,
        input logic                 prev_msb
    );
        if (d < 3'd3)
            return d;
        else if (d == 3'd3)
            return prev_msb ? 3'b100 : 3'b011;
        else
            return d + 3'd1;
    endfunction

    function automatic logic [TNS_GRP_W-1:0] tns_dec_grp(
        input logic [TNS_GRP_W-1:0] p
    );
        if (p < 3'd3)
            return p;
        else if (p <= 3'd4)
            return 3'd3;
        else
            return p - 3'd1;
    endfunction

endpackage

// File: rtl/tns_dec_06.sv
// Combinational TSV decoder: every 6-bit codeword maps to 0..48.
import tns_pkg::*;

module tns_dec_06 (
    input  logic [TNS_BLEN-1:0] tsv,
    output logic [TNS_BLEN-1:0] dataout
);

    always_comb begin
        dataout = '0;
        for (int g = TNS_NGROUP - 1; g >= 0; g--) begin
            dataout = dataout * TNS_BLEN'(TNS_RADIX)
                    + TNS_BLEN'(tns_dec_grp(tsv[g*TNS_GRP_W +: TNS_GRP_W]));
        end
    end

endmodule

// File: rtl/tns_encoder_06_grp_enc.sv
// One group of the TSV encoder: a 3-bit code register whose own MSB
// provides the history for the digit-3 code choice.
import tns_pkg::*;

module tns_grp_enc (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [TNS_GRP_W-1:0] digit,
    output logic [TNS_GRP_W-1:0] p
);

    logic [TNS_GRP_W-1:0] p_reg;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            p_reg <= '0;
        else if (en)
            p_reg <= tns_enc_grp(digit, p_reg[TNS_GRP_W-1]);
    end

    assign p = p_reg;

endmodule

// File: rtl/tns_encoder_06.sv
// TSV encoder top: splits datain into base-7 digits, one registered group
// slice per digit; out-of-range words leave the codeword untouched.
import tns_pkg::*;

module tns_encoder_06 (
    input  logic [TNS_BLEN-1:0] datain,
    input  logic                clock,
    output logic [TNS_BLEN-1:0] tsv,
    input  logic                rst_n
);

    logic                 in_range;
    logic [TNS_GRP_W-1:0] digit [TNS_NGROUP];

    assign in_range = (datain < TNS_BLEN'(TNS_CODES));

    generate
        for (genvar gi = 0; gi < TNS_NGROUP; gi++) begin : g_grp
            assign digit[gi] = TNS_GRP_W'((datain / TNS_BLEN'(TNS_RADIX ** gi))
                                          % TNS_BLEN'(TNS_RADIX));

            tns_grp_enc u_grp (
                .clock (clock),
                .rst_n (rst_n),
                .en    (in_range),
                .digit (digit[gi]),
                .p     (tsv[gi*TNS_GRP_W +: TNS_GRP_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_tns_encoder_06.sv
// Directed and random checks of tns_encoder_06 with tns_dec_06 on its output.
module tb_tns_encoder_06;

    logic       clock;
    logic       rst_n;
    logic [5:0] datain;
    logic [5:0] tsv;
    logic [5:0] dataout;

    int n_checks;
    int n_fail;

    tns_encoder_06 dut (
        .datain (datain),
        .clock  (clock),
        .tsv    (tsv),
        .rst_n  (rst_n)
    );

    tns_dec_06 u_dec (
        .tsv     (tsv),
        .dataout (dataout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply a word, take one rising edge, sample 1 time unit later.
    task automatic apply(input logic [5:0] v);
        datain = v;
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string name, input logic [5:0] exp_tsv,
                             input logic [5:0] exp_data);
        n_checks++;
        if (tsv !== exp_tsv) begin
            n_fail++;
            $display("FAIL %s tsv: got %b expected %b", name, tsv, exp_tsv);
        end
        n_checks++;
        if (dataout !== exp_data) begin
            n_fail++;
            $display("FAIL %s dataout: got %0d expected %0d", name, dataout, exp_data);
        end
        $display("txn %s datain=%0d tsv=%b dataout=%0d", name, datain, tsv, dataout);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst_n = 1'b0;
        #2;
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        datain = 6'd0;
        rst_n  = 1'b0;
        #3;
        check_out("reset", 6'b000000, 6'd0);
        @(negedge clock);
        rst_n = 1'b1;
    endtask

    task automatic test_first_three();
        apply(6'd3);
        check_out("first_three", 6'b000011, 6'd3);
    endtask

    task automatic test_sequence();
        apply(6'd24);
        check_out("seq_24a", 6'b011011, 6'd24);
        apply(6'd48);
        check_out("seq_48", 6'b111111, 6'd48);
        apply(6'd24);
        check_out("seq_24b", 6'b100100, 6'd24);
    endtask

    task automatic test_out_of_range();
        apply(6'd50);
        check_out("oor_50", 6'b100100, 6'd24);
        apply(6'd63);
        check_out("oor_63", 6'b100100, 6'd24);
        apply(6'd49);
        check_out("oor_49", 6'b100100, 6'd24);
    endtask

    task automatic test_async_reset();
        apply(6'd48);
        check_out("pre_async", 6'b111111, 6'd48);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_mid", 6'b000000, 6'd0);
        @(negedge clock);
        rst_n = 1'b1;
        apply(6'd24);
        check_out("post_async_24", 6'b011011, 6'd24);
    endtask

    task automatic test_digits();
        do_reset();
        apply(6'd6);
        check_out("dig_6", 6'b000111, 6'd6);
        apply(6'd7);
        check_out("dig_7", 6'b001000, 6'd7);
        apply(6'd45);
        check_out("dig_45", 6'b111011, 6'd45);
        apply(6'd10);
        check_out("dig_10", 6'b001011, 6'd10);
        apply(6'd21);
        check_out("dig_21", 6'b011000, 6'd21);
        apply(6'd46);
        check_out("dig_46", 6'b111101, 6'd46);
        apply(6'd3);
        check_out("dig_3_hist1", 6'b000100, 6'd3);
        apply(6'd0);
        check_out("dig_0", 6'b000000, 6'd0);
    endtask

    task automatic test_random();
        logic [5:0] prev_tsv;
        logic [5:0] v;
        logic [2:0] p;
        int         rnd_fail;
        rnd_fail = 0;
        for (int i = 0; i < 10000; i++) begin
            prev_tsv = tsv;
            v = 6'($urandom_range(48, 0));
            apply(v);
            n_checks++;
            if (dataout !== v) begin
                n_fail++;
                rnd_fail++;
                if (rnd_fail <= 10)
                    $display("FAIL random_data[%0d]: got %0d expected %0d", i, dataout, v);
            end
            for (int g = 0; g < 2; g++) begin
                p = tsv[g*3 +: 3];
                n_checks++;
                if ((prev_tsv[g*3+2] == 1'b0 && p == 3'b100) ||
                    (prev_tsv[g*3+2] == 1'b1 && p == 3'b011)) begin
                    n_fail++;
                    rnd_fail++;
                    if (rnd_fail <= 10)
                        $display("FAIL random_hist[%0d] g%0d: got %b after msb %b, required other code",
                                 i, g, p, prev_tsv[g*3+2]);
                end
            end
        end
        $display("txn random 10000 words, %0d errors", rnd_fail);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        datain   = 6'd0;
        rst_n    = 1'b1;
        test_reset();
        test_first_three();
        test_sequence();
        test_out_of_range();
        test_async_reset();
        test_digits();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tns_encoder_06.md
TNS_ENCODER_06 -- requirements
Module: tns_encoder_06

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from package constants (REQ-020).
REQ-002 Port list (clock and reset first) SHALL be:
- `clock  in  1  rising-edge clock`
- `rst_n  in  1  reset, asynchronous, active-low`
- `datain  in  6  data word, legal range 0..48`
- `tsv  out  6  registered TSV codeword, two 3-bit groups`

REQ-003 Positional port order SHALL be (datain, clock, tsv, rst_n), so that existing 3-port positional instantiations keep their meaning.
REQ-004 Companion decoder tns_dec_06 SHALL have ports, in this positional order:
- `tsv  in  6  codeword`
- `dataout  out  6  decoded word`

REQ-005 There SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-006 datain SHALL be split into base-7 digits: d0 = datain mod 7 and d1 = datain div 7.
REQ-007 d0 SHALL be encoded in group 0 (tsv[2:0]) and d1 in group 1 (tsv[5:3]).
REQ-008 Within each group, P = {tsv[3j+2], tsv[3j+1], tsv[3j]}.
REQ-009 Group encoding SHALL be:
- d = 0..2 -> P = d
- d = 3 -> P = 3'b011 if the previous tsv[3j+2] = 0, else 3'b100
- d = 4..6 -> P = d + 1
REQ-010 "Previous" SHALL mean the group's tsv[3j+2] value currently held in the output register, before the clock edge.
REQ-011 Consequently, P = 3'b100 SHALL never follow a group MSB of 0, and P = 3'b011 SHALL never follow a group MSB of 1.
REQ-012 tsv SHALL update only on the rising clock edge; latency is one cycle from datain to tsv.
REQ-013 If datain > 48, the encoder SHALL hold tsv unchanged on that edge.
REQ-014 The decoder SHALL be purely combinational and stateless.
REQ-015 Decoder group decode SHALL be:
- P = 0..2 -> d = P
- P = 3 or 4 -> d = 3
- P = 5..7 -> d = P - 1
REQ-016 The decoder SHALL output dataout = d1*7 + d0, computed in 6 bits without overflow (maximum 48).
REQ-017 Every 6-bit tsv input SHALL decode to a value in 0..48; there are no illegal decoder inputs.

Reset
REQ-018 While rst_n = 0, tsv SHALL be 6'b000000 immediately, independent of clock; the decoder then outputs 0.
REQ-019 After rst_n is released, the group history bits SHALL be 0, so the first d = 3 is encoded as 3'b011.

Structure
REQ-020 Package tns_pkg SHALL hold:
- TNS_BLEN = 6
- TNS_NGROUP = 2
- TNS_GRP_W = 3
- TNS_CODES = 49
- TNS_RADIX = 7
- encode and decode group functions
REQ-021 The natural sub-module is one per-group encoder slice, tns_grp_enc, instantiated TNS_NGROUP times inside tns_encoder_06; tns_dec_06 SHALL be a separate module reusing the package decode function.

Verification
REQ-022 Reset: assert rst_n = 0 -> tsv = 6'b000000 and dataout = 0.
REQ-023 After reset, datain = 3, one edge -> tsv = 6'b000011 and dataout = 3.
REQ-024 Sequence 24, 48, 24 on successive edges:
- 24 -> tsv = 6'b011011
- 48 -> tsv = 6'b111111
- 24 -> tsv = 6'b100100 (history = 1)
- dataout = 24, 48, 24 respectively
REQ-025 Out of range: with tsv = 6'b100100, apply datain = 50, one edge -> tsv stays 6'b100100 and dataout stays 24.
REQ-026 Asynchronous reset mid-operation: drop rst_n between edges while tsv = 6'b111111 -> tsv = 0 before the next edge.
REQ-027 Random run: 10000 values in 0..48 -> dataout == datain one edge later, and for each group P never equals 3'b100 after MSB 0 or 3'b011 after MSB 1; error count is 0.
